// File: rtl/tff_mode_counter.sv
// Multi-mode synchronous counter built on a bank of T flip-flops.
// Modes: binary up, binary down (both modulo MODULUS), Gray up, and Johnson.
module tff_mode_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             terminal_count,
    output logic             wrap,
    output logic [WIDTH-1:0] toggle
);

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_GRAY    = 2'b10;
    localparam logic [1:0] MODE_JOHNSON = 2'b11;

    localparam logic [WIDTH-1:0] MOD_LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] step_toggle;
    logic [WIDTH-2:0] ring_edges;
    logic             johnson_valid;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // A twisted-ring code has at most one boundary between adjacent bits.
    assign ring_edges    = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    assign johnson_valid = $onehot0(ring_edges);

    always_comb begin
        next_q = q;
        case (mode)
            MODE_UP:      next_q = (q >= MOD_LAST) ? '0 : q + WIDTH'(1);
            MODE_DOWN:    next_q = (q == '0) ? MOD_LAST : q - WIDTH'(1);
            MODE_GRAY:    next_q = bin2gray(gray2bin(q) + WIDTH'(1));
            MODE_JOHNSON: next_q = johnson_valid ? {q[WIDTH-2:0], ~q[WIDTH-1]} : '0;
            default:      next_q = q;
        endcase
    end

    always_comb begin
        terminal_count = 1'b0;
        case (mode)
            MODE_UP:   terminal_count = (q == MOD_LAST);
            MODE_DOWN: terminal_count = (q == '0);
            default:   terminal_count = (q == MSB_ONLY);
        endcase
    end

    // T inputs: each bit toggles where the next state differs.
    assign step_toggle = q ^ next_q;

    // Every mode's terminal state steps to its start state, so wrap is just
    // "terminal on an enabled count step".
    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= '0;
            wrap   <= 1'b0;
            toggle <= '0;
        end else if (load) begin
            q      <= load_value;
            wrap   <= 1'b0;
            toggle <= q ^ load_value;
        end else if (enable) begin
            q      <= q ^ step_toggle;
            wrap   <= terminal_count;
            toggle <= step_toggle;
        end else begin
            wrap   <= 1'b0;
            toggle <= '0;
        end
    end

endmodule

// File: tb/tb_tff_mode_counter.sv
// Directed bench for tff_mode_counter (WIDTH=4, MODULUS=10) using an
// expectation queue filled at drive time and drained after each edge.
module tb_tff_mode_counter;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MODULUS = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [1:0]       mode;
    logic [WIDTH-1:0] q;
    logic             terminal_count;
    logic             wrap;
    logic [WIDTH-1:0] toggle;

    tff_mode_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .load           (load),
        .load_value     (load_value),
        .mode           (mode),
        .q              (q),
        .terminal_count (terminal_count),
        .wrap           (wrap),
        .toggle         (toggle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] q;
        logic       wrap;
        logic [3:0] tog;
        logic       tc;
    } exp_t;

    exp_t        sb[$];
    string       tags[$];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_prev_q = 4'b0000;
    logic [3:0]  jseq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                              4'b1110, 4'b1100, 4'b1000, 4'b0000};

    function automatic logic tc_of(input logic [1:0] m, input logic [3:0] v);
        case (m)
            2'b00:   return v == 4'd9;
            2'b01:   return v == 4'd0;
            default: return v == 4'b1000;
        endcase
    endfunction

    task automatic cmp(input string tag, input string field,
                       input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, field, obs, expv);
        end
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            t = tags.pop_front();
            cmp(t, "q", q, e.q);
            cmp(t, "wrap", {3'b000, wrap}, {3'b000, e.wrap});
            cmp(t, "toggle", toggle, e.tog);
            cmp(t, "tc", {3'b000, terminal_count}, {3'b000, e.tc});
        end
    endtask

    // Drive one edge's inputs, queue the expected outcome, then check it.
    task automatic step(input string tag, input logic r, input logic ld,
                        input logic en, input logic [3:0] lv, input logic [1:0] m,
                        input logic [3:0] eq, input logic ew);
        exp_t e;
        reset      = r;
        load       = ld;
        enable     = en;
        load_value = lv;
        mode       = m;
        e.q    = eq;
        e.wrap = ew;
        e.tog  = r ? 4'b0000 : ((ld || en) ? (exp_prev_q ^ eq) : 4'b0000);
        e.tc   = tc_of(m, eq);
        sb.push_back(e);
        tags.push_back(tag);
        exp_prev_q = eq;
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        // Binary up, modulo 10.
        step("rst_up", 1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step("up", 1'b0, 1'b0, 1'b1, 4'h0, 2'b00, 4'(i % 10), i == 10);
        end

        // Binary down from reset: terminal at 0 before counting, then 9,8,7.
        step("rst_down", 1'b1, 1'b0, 1'b0, 4'h0, 2'b01, 4'h0, 1'b0);
        step("down", 1'b0, 1'b0, 1'b1, 4'h0, 2'b01, 4'd9, 1'b1);
        step("down", 1'b0, 1'b0, 1'b1, 4'h0, 2'b01, 4'd8, 1'b0);
        step("down", 1'b0, 1'b0, 1'b1, 4'h0, 2'b01, 4'd7, 1'b0);

        // Out-of-range value counts down into range.
        step("down_ld", 1'b0, 1'b1, 1'b0, 4'hF, 2'b01, 4'hF, 1'b0);
        step("down_oor", 1'b0, 1'b0, 1'b1, 4'h0, 2'b01, 4'hE, 1'b0);

        // Gray up over a full cycle; each step flips exactly one bit.
        step("rst_gray", 1'b1, 1'b0, 1'b0, 4'h0, 2'b10, 4'h0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] b;
            b = 4'(i);
            step("gray", 1'b0, 1'b0, 1'b1, 4'h0, 2'b10, b ^ (b >> 1), i == 16);
            checks++;
            assert ($onehot(toggle)) else begin
                errors++;
                $error("FAIL gray.onehot observed=%b expected=one bit set", toggle);
            end
        end

        // Johnson: invalid code self-corrects to 0 without wrap.
        step("john_ld", 1'b0, 1'b1, 1'b0, 4'b0101, 2'b11, 4'b0101, 1'b0);
        step("john_fix", 1'b0, 1'b0, 1'b1, 4'h0, 2'b11, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("john", 1'b0, 1'b0, 1'b1, 4'h0, 2'b11, jseq[i], i == 7);
        end

        // Load beats enable; reset beats load.
        step("ld_en", 1'b0, 1'b1, 1'b1, 4'b0110, 2'b00, 4'b0110, 1'b0);
        step("rst_ld", 1'b1, 1'b1, 1'b1, 4'b1011, 2'b00, 4'b0000, 1'b0);

        // Out-of-range in up mode goes to 0 without wrap, then holds.
        step("up_ld", 1'b0, 1'b1, 1'b0, 4'b1101, 2'b00, 4'b1101, 1'b0);
        step("up_oor", 1'b0, 1'b0, 1'b1, 4'h0, 2'b00, 4'b0000, 1'b0);
        step("hold", 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 4'b0000, 1'b0);
        step("hold", 1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 4'b0000, 1'b0);

        // Mode change mid-run applies to current q: 1 in up, then down to 0.
        step("mc_up", 1'b0, 1'b0, 1'b1, 4'h0, 2'b00, 4'd1, 1'b0);
        step("mc_down", 1'b0, 1'b0, 1'b1, 4'h0, 2'b01, 4'd0, 1'b0);
        step("mc_wrap", 1'b0, 1'b0, 1'b1, 4'h0, 2'b01, 4'd9, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
